// File: rtl/ras_sequencer.sv
// rtl/ras_sequencer.sv - return address stack command sequencer.
// Turns call/ret/branch decode into RAS pulses and retires speculative branch checkpoints oldest-first.
module ras_sequencer #(
  parameter int WIDTH         = 32,
  parameter int MAXBRANCHES   = 16,
  parameter int BRANCHES_ADDR = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_call,
  input  logic                     in_ret,
  input  logic                     in_branch,
  input  logic [WIDTH-1:0]         in_ret_addr,
  output logic [BRANCHES_ADDR-1:0] br_tag,
  input  logic                     res_valid,
  input  logic [BRANCHES_ADDR-1:0] res_tag,
  input  logic                     res_mispredict,
  output logic                     ras_push,
  output logic                     ras_pop,
  output logic                     ras_branch,
  output logic                     ras_close_valid,
  output logic                     ras_close_invalid,
  output logic [WIDTH-1:0]         ras_din,
  input  logic [WIDTH-1:0]         ras_dout,
  input  logic                     ras_pop_valid,
  output logic                     pred_valid,
  output logic [WIDTH-1:0]         pred_addr,
  output logic                     flush,
  output logic [BRANCHES_ADDR:0]   outstanding
);

  localparam int PW = BRANCHES_ADDR + 1;

  logic [PW-1:0]            head, tail, count;
  logic [MAXBRANCHES-1:0]   resolved, mispred;
  logic [BRANCHES_ADDR-1:0] head_idx, tail_idx, res_off;
  logic                     head_ok, head_bad, flush_pending, accept, res_hit;

  always_comb begin
    count         = tail - head;
    head_idx      = head[BRANCHES_ADDR-1:0];
    tail_idx      = tail[BRANCHES_ADDR-1:0];
    head_ok       = (count != '0) && resolved[head_idx] && !mispred[head_idx];
    head_bad      = (count != '0) && resolved[head_idx] && mispred[head_idx];
    // Stall both while the mispredict waits at the head and during the flush cycle itself.
    flush_pending = head_bad || flush;
    in_ready      = (count < PW'(MAXBRANCHES)) && !flush_pending;
    accept        = in_valid && in_ready;
    // Window test is relative to head so it stays correct across tag wrap.
    res_off       = res_tag - head_idx;
    res_hit       = res_valid && (PW'(res_off) < count) && !resolved[res_tag];
  end

  assign outstanding = count;
  assign br_tag      = tail_idx;
  assign pred_addr   = pred_valid ? ras_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head              <= '0;
      tail              <= '0;
      resolved          <= '0;
      mispred           <= '0;
      ras_push          <= 1'b0;
      ras_pop           <= 1'b0;
      ras_branch        <= 1'b0;
      ras_close_valid   <= 1'b0;
      ras_close_invalid <= 1'b0;
      ras_din           <= '0;
      pred_valid        <= 1'b0;
      flush             <= 1'b0;
    end else begin
      ras_push          <= 1'b0;
      ras_pop           <= 1'b0;
      ras_branch        <= 1'b0;
      ras_close_valid   <= 1'b0;
      ras_close_invalid <= 1'b0;
      flush             <= 1'b0;
      pred_valid        <= ras_pop && ras_pop_valid;
      if (head_bad) begin
        ras_close_invalid <= 1'b1;
        flush             <= 1'b1;
        tail              <= head;
        resolved          <= '0;
        mispred           <= '0;
      end else begin
        if (accept) begin
          if (in_branch) begin
            ras_branch         <= 1'b1;
            tail               <= tail + 1'b1;
            resolved[tail_idx] <= 1'b0;
            mispred[tail_idx]  <= 1'b0;
          end else begin
            ras_push <= in_call;
            ras_pop  <= in_ret;
            if (in_call) ras_din <= in_ret_addr;
          end
        end
        if (res_hit) begin
          resolved[res_tag] <= 1'b1;
          mispred[res_tag]  <= res_mispredict;
        end
        // A resolved head cannot also be the resolution target, so these never collide.
        if (head_ok) begin
          ras_close_valid    <= 1'b1;
          head               <= head + 1'b1;
          resolved[head_idx] <= 1'b0;
          mispred[head_idx]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ras_sequencer.sv
// tb/tb_ras_sequencer.sv - randomized bench for ras_sequencer against a queue-based reference model.
module tb_ras_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_call, in_ret, in_branch;
  logic [31:0] in_ret_addr;
  logic [3:0]  br_tag;
  logic        res_valid, res_mispredict;
  logic [3:0]  res_tag;
  logic        ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
  logic [31:0] ras_din, ras_dout, pred_addr;
  logic        ras_pop_valid, pred_valid, flush;
  logic [4:0]  outstanding;

  int vectors = 0;
  int miscompares = 0;

  ras_sequencer #(.WIDTH(32), .MAXBRANCHES(16), .BRANCHES_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_call(in_call), .in_ret(in_ret), .in_branch(in_branch), .in_ret_addr(in_ret_addr),
    .br_tag(br_tag), .res_valid(res_valid), .res_tag(res_tag), .res_mispredict(res_mispredict),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
    .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
    .ras_din(ras_din), .ras_dout(ras_dout), .ras_pop_valid(ras_pop_valid),
    .pred_valid(pred_valid), .pred_addr(pred_addr), .flush(flush), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  // Environment RAS: plain stack answering pops, pop before push on a swap.
  logic [31:0] rstk[$];
  int          rsize;
  assign ras_pop_valid = ras_pop && (rsize != 0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstk.delete();
      rsize    <= 0;
      ras_dout <= '0;
    end else begin
      if (ras_pop && rstk.size() > 0) ras_dout <= rstk.pop_back();
      if (ras_push) rstk.push_back(ras_din);
      rsize <= rstk.size();
    end
  end

  // Reference model: in-order list of live branches, oldest first.
  typedef struct packed { bit res; bit mis; } ent_t;
  ent_t        q[$];
  logic [31:0] mstk[$];
  int          head_cnt, tail_cnt;
  bit          e_push, e_pop, e_branch, e_cv, e_ci, e_flush, e_pv;
  logic [31:0] e_din, e_pa;

  function automatic bit m_head_bad();
    return q.size() > 0 && q[0].res && q[0].mis;
  endfunction

  function automatic bit m_ready();
    return q.size() < 16 && !m_head_bad() && !e_flush;
  endfunction

  task automatic model_reset();
    q.delete(); mstk.delete();
    head_cnt = 0; tail_cnt = 0;
    {e_push, e_pop, e_branch, e_cv, e_ci, e_flush, e_pv} = '0;
    e_din = '0; e_pa = '0;
  endtask

  task automatic model_step();
    bit   hb, ok, acc;
    int   off;
    ent_t e;
    if (!rst_n) begin model_reset(); return; end
    e_pv = e_pop && mstk.size() > 0;
    e_pa = e_pv ? mstk.pop_back() : 32'h0;
    if (e_push) mstk.push_back(e_din);
    hb  = m_head_bad();
    acc = in_valid && m_ready();
    {e_push, e_pop, e_branch, e_cv, e_ci, e_flush} = '0;
    if (hb) begin
      e_ci = 1; e_flush = 1;
      q.delete();
      tail_cnt = head_cnt;
    end else begin
      ok = q.size() > 0 && q[0].res && !q[0].mis;
      if (res_valid) begin
        off = (int'(res_tag) - head_cnt % 16 + 16) % 16;
        if (off < q.size() && !q[off].res) begin
          e = q[off]; e.res = 1; e.mis = res_mispredict; q[off] = e;
        end
      end
      if (acc) begin
        if (in_branch) begin
          e_branch = 1; q.push_back(2'b00); tail_cnt++;
        end else begin
          e_push = in_call; e_pop = in_ret;
          if (in_call) e_din = in_ret_addr;
        end
      end
      if (ok) begin
        void'(q.pop_front()); head_cnt++; e_cv = 1;
      end
    end
  endtask

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  always @(negedge clk) begin
    chk("ras_push", ras_push, e_push);
    chk("ras_pop", ras_pop, e_pop);
    chk("ras_branch", ras_branch, e_branch);
    chk("ras_close_valid", ras_close_valid, e_cv);
    chk("ras_close_invalid", ras_close_invalid, e_ci);
    chk("flush", flush, e_flush);
    chk("ras_din", ras_din, e_din);
    chk("pred_valid", pred_valid, e_pv);
    chk("pred_addr", pred_addr, e_pa);
    chk("in_ready", in_ready, m_ready());
    chk("br_tag", br_tag, tail_cnt % 16);
    chk("outstanding", outstanding, q.size());
  end

  task automatic set_in(bit v, bit c, bit r, bit b, logic [31:0] a);
    in_valid = v; in_call = c; in_ret = r; in_branch = b; in_ret_addr = a;
  endtask

  task automatic set_res(bit v, int tag, bit m);
    res_valid = v; res_tag = 4'(tag); res_mispredict = m;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 32'h0);
    set_res(0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && q.size() > 0; k++) begin
      idle();
      for (int j = 0; j < q.size(); j++)
        if (!q[j].res) begin set_res(1, (head_cnt + j) % 16, 0); break; end
      step();
    end
    idle(); step(); step();
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_outstanding", outstanding, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_br_tag", br_tag, 0);

    // call then ret: push in cycle 1, pop in cycle 3, prediction in cycle 4
    set_in(1, 1, 0, 0, 32'h0000_1004); step();
    chk("t1_push", ras_push, 1); chk("t1_din", ras_din, 32'h1004);
    idle(); step();
    set_in(1, 0, 1, 0, 32'h0); step();
    chk("t1_pop", ras_pop, 1);
    idle(); step();
    chk("t1_pred_valid", pred_valid, 1); chk("t1_pred_addr", pred_addr, 32'h1004);

    // fill the tracker
    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 0, 1, 32'h0);
      chk("t2_br_tag", br_tag, i);
      step();
    end
    idle(); step();
    chk("t2_full_outstanding", outstanding, 16); chk("t2_full_ready", in_ready, 0);
    set_res(1, 0, 0); step();
    idle(); step();
    chk("t2_close", ras_close_valid, 1); chk("t2_outstanding", outstanding, 15);
    chk("t2_ready", in_ready, 1);
    drain();

    // out-of-order resolution closes in order
    t = tail_cnt % 16;
    for (int i = 0; i < 3; i++) begin set_in(1, 0, 0, 1, 32'h0); step(); end
    idle(); set_res(1, (t + 2) % 16, 0); step(); chk("t3_c0", ras_close_valid, 0);
    set_res(1, (t + 1) % 16, 0); step(); chk("t3_c1", ras_close_valid, 0);
    set_res(1, t, 0); step(); chk("t3_c2", ras_close_valid, 0);
    idle(); step(); chk("t3_close_a", ras_close_valid, 1);
    step(); chk("t3_close_b", ras_close_valid, 1);
    step(); chk("t3_close_c", ras_close_valid, 1);
    step(); chk("t3_done", ras_close_valid, 0); chk("t3_outstanding", outstanding, 0);

    // younger mispredict waits for head, then flushes; held-off call
    t = tail_cnt % 16;
    for (int i = 0; i < 2; i++) begin set_in(1, 0, 0, 1, 32'h0); step(); end
    idle(); set_res(1, (t + 1) % 16, 1); step();
    set_res(1, t, 0); step();
    idle(); step();
    chk("t4_close_valid", ras_close_valid, 1); chk("t4_stall", in_ready, 0);
    set_in(1, 1, 0, 0, 32'h0000_2008); step();
    chk("t4_close_invalid", ras_close_invalid, 1); chk("t4_flush", flush, 1);
    chk("t4_outstanding", outstanding, 0); chk("t4_flush_ready", in_ready, 0);
    chk("t4_no_push", ras_push, 0);
    step();
    chk("t4_held_push", ras_push, 0); chk("t4_ready_back", in_ready, 1);
    step();
    chk("t4_late_push", ras_push, 1); chk("t4_late_din", ras_din, 32'h2008);
    idle(); step();

    // coroutine swap and branch priority
    set_in(1, 1, 1, 0, 32'h0000_abcd); step();
    chk("t5_swap_push", ras_push, 1); chk("t5_swap_pop", ras_pop, 1);
    set_in(1, 1, 0, 1, 32'h0000_5555); step();
    chk("t5_br_branch", ras_branch, 1); chk("t5_br_push", ras_push, 0);
    drain();

    // reset with five branches in flight
    for (int i = 0; i < 5; i++) begin set_in(1, 0, 0, 1, 32'h0); step(); end
    idle(); step();
    chk("t6_pre_outstanding", outstanding, 5);
    rst_n = 1'b0; model_reset(); #1;
    chk("t6_outstanding", outstanding, 0); chk("t6_close", ras_close_valid, 0);
    chk("t6_invalid", ras_close_invalid, 0); chk("t6_flush", flush, 0);
    chk("t6_br_tag", br_tag, 0);
    step(); step();
    rst_n = 1'b1;
    set_in(1, 0, 0, 1, 32'h0);
    chk("t6_new_tag", br_tag, 0);
    step();
    chk("t6_branch", ras_branch, 1);
    drain();

    // randomized traffic, with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        set_res($urandom_range(0, 1), (head_cnt + $urandom_range(0, q.size() - 1)) % 16,
                $urandom_range(0, 6) == 0);
      else
        set_res($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 1));
      if (i == 1500) begin rst_n = 1'b0; model_reset(); end
      if (i == 1503) rst_n = 1'b1;
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ras_sequencer.md
Name: ras_sequencer

Overview:
- Front-end command generator that drives the return address stack (RAS).
- Accepts a decoded instruction stream (call / return / conditional branch) and branch-resolution feedback from the back end.
- Emits single-cycle push, pop, branch, close_valid and close_invalid pulses to the RAS, and returns the predicted return address.
- Tracks outstanding speculative branches in order, so that RAS checkpoints are closed oldest-first.

Parameters:
WIDTH, 32, return-address width
MAXBRANCHES, 16, maximum number of outstanding speculative branches (must equal the RAS checkpoint depth)
BRANCHES_ADDR, 4, log2(MAXBRANCHES); width of a branch tag

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction presented
in_ready  out  1  instruction accepted when in_valid && in_ready
in_call  in  1  instruction is a call
in_ret  in  1  instruction is a return
in_branch  in  1  instruction is a conditional branch
in_ret_addr  in  WIDTH  return address pushed by a call
br_tag  out  BRANCHES_ADDR  tag assigned to the branch accepted this cycle
res_valid  in  1  branch resolution strobe
res_tag  in  BRANCHES_ADDR  tag being resolved
res_mispredict  in  1  1 = branch was mispredicted
ras_push  out  1  RAS push pulse
ras_pop  out  1  RAS pop pulse
ras_branch  out  1  RAS open-checkpoint pulse
ras_close_valid  out  1  RAS close oldest checkpoint as correct
ras_close_invalid  out  1  RAS discard all checkpoints
ras_din  out  WIDTH  data pushed to the RAS
ras_dout  in  WIDTH  RAS read data (valid the cycle after ras_pop)
ras_pop_valid  in  1  RAS pop-hit, same cycle as ras_pop
pred_valid  out  1  predicted return address valid
pred_addr  out  WIDTH  predicted return address
flush  out  1  misprediction recovery pulse to the front end
outstanding  out  BRANCHES_ADDR+1  number of unresolved or unretired branches

Behaviour:
- Reset, asynchronous on rst_n low: all ras_* outputs, pred_valid, flush and outstanding are 0; ras_din, pred_addr and br_tag are 0; head/tail pointers are 0; resolution bitmaps are cleared. Reset mid-operation drops all tracked branches with no close pulse emitted.
- Tracker: circular buffer of MAXBRANCHES entries.
  - Each entry holds two bits: resolved and mispredict.
  - Head and tail pointers are BRANCHES_ADDR+1 bits wide, with a wrap bit.
  - Tag = tail[BRANCHES_ADDR-1:0]. outstanding = tail - head.
- in_ready = (outstanding < MAXBRANCHES) && !flush_pending. A full tracker stalls every instruction type, not only branches.
- Acceptance at edge N drives the registered pulses in cycle N+1, each high for exactly one cycle:
  - in_branch has priority: ras_branch=1; in_call and in_ret are ignored; br_tag is the current tail (combinational, valid during acceptance); tail increments.
  - in_call alone: ras_push=1, ras_din=in_ret_addr.
  - in_ret alone: ras_pop=1.
  - in_call && in_ret (coroutine swap): ras_push=1 and ras_pop=1 in the same cycle.
  - None of the three set: no pulse.
- Prediction: pred_valid = registered ras_pop_valid; pred_addr = ras_dout, sampled the cycle after ras_pop. Total latency from return acceptance to pred_valid is 2 cycles. If the RAS is empty, pred_valid stays 0.
- Resolution: res_valid with res_tag inside [head, tail) sets resolved and mispredict for that entry. Out-of-order resolution is allowed. A tag outside the window, a tag already resolved, or the tag being allocated in the same cycle is ignored.
- Retirement: one per cycle, examined at the head.
  - Head resolved and correct: ras_close_valid=1 next cycle; head increments; the entry is cleared. This may coincide with instruction pulses.
  - Head resolved and mispredicted: flush_pending is set. Next cycle ras_close_invalid=1 and flush=1; tail := head; all entries are cleared; no other ras_* pulse is issued that cycle; in_ready=0 during that cycle.
  - A younger mispredict waits until it reaches the head.
- Simultaneous events:
  - Branch acceptance and head retirement in the same cycle: outstanding is unchanged.
  - An in_valid offered while flush_pending is held off until flush completes.
- Wrap-around: pointers wrap modulo 2*MAXBRANCHES; tags wrap modulo MAXBRANCHES.

Test Plan:
- Reset, then call with in_ret_addr=0x0000_1004, then ret -> ras_push=1 with ras_din=0x1004 in cycle 1; ras_pop=1 in cycle 3; pred_valid=1 with pred_addr=0x1004 in cycle 4.
- Issue 16 branches back-to-back -> br_tag 0..15; outstanding=16; in_ready=0. Resolve tag 0 correct -> ras_close_valid one cycle later, outstanding=15, in_ready=1.
- Branches with tags 0,1,2; resolve 2 correct, then 1 correct, then 0 correct -> three consecutive ras_close_valid pulses, only after tag 0 resolves.
- Branches with tags 0,1; resolve 1 mispredict, then 0 correct -> ras_close_valid (tag 0), then ras_close_invalid with flush=1; outstanding=0.
- Call and ret asserted together -> ras_push=1 and ras_pop=1 in the same cycle; in_branch together with in_call -> only ras_branch.
- Assert rst_n low with 5 branches outstanding -> all outputs 0 immediately, no close pulse; first new branch gets br_tag=0.
